// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath types and register constants
package mips_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  reg_addr_t;

  localparam int        NUM_REGS = 32;
  localparam reg_addr_t ZERO_REG = 5'd0;
  localparam reg_addr_t RA_REG   = 5'd31;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, search starts one past the last winner
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         upd_en,
  output logic [N-1:0] gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr;
    cand    = ptr;
    found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand = PW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (found && !rst) gnt[gnt_idx] = 1'b1;
  end

  // Reset to N-1 so index 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) ptr <= PW'(N - 1);
    else if (upd_en && found) ptr <= gnt_idx;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - arbitrates write-back sources onto the register file write port
module regfile_wb_scheduler
  import mips_pkg::*;
#(
  parameter int NUM_SRC  = 3,
  parameter int LINK_SRC = 2,
  parameter int PEND_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_req,
  input  logic [NUM_SRC-1:0][4:0]   src_addr,
  input  logic [NUM_SRC-1:0][31:0]  src_data,
  output logic [NUM_SRC-1:0]        src_gnt,
  input  logic                      iss_valid,
  input  logic [4:0]                iss_addr,
  output logic                      iss_ready,
  input  logic [4:0]                qry_addr0,
  input  logic [4:0]                qry_addr1,
  output logic                      qry_busy0,
  output logic                      qry_busy1,
  output logic                      wr_en,
  output logic [4:0]                wr_addr,
  output logic [31:0]               wr_data,
  output logic                      jump_and_link,
  output logic                      sb_err
);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NUM_SRC-1:0]  xfer_vec;
  logic                xfer;
  reg_addr_t           sel_addr;
  word_t               sel_data;
  logic                sel_link;

  assign xfer_vec = src_req & src_gnt;
  assign xfer     = |xfer_vec;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (src_req),
    .upd_en (xfer),
    .gnt    (src_gnt)
  );

  always_comb begin
    sel_addr = ZERO_REG;
    sel_data = '0;
    sel_link = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (xfer_vec[i]) begin
        sel_addr = src_addr[i];
        sel_data = src_data[i];
        sel_link = (i == LINK_SRC);
      end
    end
  end

  // wr_addr/wr_data keep their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en         <= 1'b0;
      jump_and_link <= 1'b0;
      wr_addr       <= ZERO_REG;
      wr_data       <= '0;
    end else begin
      wr_en         <= xfer && !sel_link && (sel_addr != ZERO_REG);
      jump_and_link <= xfer && sel_link;
      if (xfer) begin
        wr_addr <= sel_link ? RA_REG : sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  logic [PEND_W-1:0]   pend [NUM_REGS];
  logic [NUM_REGS-1:0] set_hit;
  logic [NUM_REGS-1:0] clr_hit;
  logic                set_v;
  logic                clr_v;
  reg_addr_t           clr_addr;
  logic                err_evt;

  assign iss_ready = (pend[iss_addr] != PEND_MAX);
  assign set_v     = iss_valid && iss_ready && (iss_addr != ZERO_REG);
  assign clr_v     = wr_en || jump_and_link;
  assign clr_addr  = jump_and_link ? RA_REG : wr_addr;
  assign qry_busy0 = (pend[qry_addr0] != '0);
  assign qry_busy1 = (pend[qry_addr1] != '0);

  // Underflow is only an error when no same-register issue offsets the clear.
  assign err_evt = (iss_valid && !iss_ready) ||
                   (clr_v && (pend[clr_addr] == '0) && !(set_v && (iss_addr == clr_addr)));

  always_comb begin
    set_hit = '0;
    clr_hit = '0;
    if (set_v) set_hit[iss_addr] = 1'b1;
    if (clr_v) clr_hit[clr_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_err <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) pend[r] <= '0;
    end else begin
      if (err_evt) sb_err <= 1'b1;
      for (int r = 1; r < NUM_REGS; r++) begin
        if (set_hit[r] && !clr_hit[r])
          pend[r] <= pend[r] + 1'b1;
        else if (clr_hit[r] && !set_hit[r] && (pend[r] != '0))
          pend[r] <= pend[r] - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench with a reference model of grants, writes and pending counts
module tb_regfile_wb_scheduler;
  localparam int NS       = 3;
  localparam int LINK     = 2;
  localparam int PEND_MAX = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    src_req;
  logic [NS-1:0][4:0]  src_addr;
  logic [NS-1:0][31:0] src_data;
  logic [NS-1:0]    src_gnt;
  logic             iss_valid;
  logic [4:0]       iss_addr;
  logic             iss_ready;
  logic [4:0]       qry_addr0, qry_addr1;
  logic             qry_busy0, qry_busy1;
  logic             wr_en, jump_and_link, sb_err;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;

  regfile_wb_scheduler #(.NUM_SRC(NS), .LINK_SRC(LINK), .PEND_W(2)) dut (
    .clk(clk), .rst(rst),
    .src_req(src_req), .src_addr(src_addr), .src_data(src_data), .src_gnt(src_gnt),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .qry_addr0(qry_addr0), .qry_addr1(qry_addr1),
    .qry_busy0(qry_busy0), .qry_busy1(qry_busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .jump_and_link(jump_and_link), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: pending counts per register, sticky error, last winner.
  int          cnt [32];
  bit          m_err;
  int          m_ptr;
  bit          due_v;
  int          due_a;
  int          m_gi;
  bit          m_rdy;
  bit          m_set;
  logic [38:0] exp_q [$];

  always @(negedge clk) begin
    if (rst) begin
      chk("gnt_in_reset", 64'(src_gnt), 64'd0);
      foreach (cnt[r]) cnt[r] = 0;
      m_err = 1'b0;
      m_ptr = NS - 1;
      due_v = 1'b0;
    end else begin
      m_rdy = (cnt[iss_addr] < PEND_MAX);
      chk("iss_ready", 64'(iss_ready), 64'(m_rdy));
      chk("qry_busy0", 64'(qry_busy0), 64'(cnt[qry_addr0] != 0));
      chk("qry_busy1", 64'(qry_busy1), 64'(cnt[qry_addr1] != 0));
      chk("sb_err", 64'(sb_err), 64'(m_err));

      m_gi = -1;
      for (int k = 1; k <= NS; k++)
        if (m_gi < 0 && src_req[(m_ptr + k) % NS]) m_gi = (m_ptr + k) % NS;
      chk("src_gnt", 64'(src_gnt), (m_gi < 0) ? 64'd0 : (64'd1 << m_gi));

      m_set = iss_valid && m_rdy && (iss_addr != 0);
      if (iss_valid && !m_rdy) m_err = 1'b1;
      if (!(due_v && m_set && due_a == int'(iss_addr))) begin
        if (m_set) cnt[iss_addr]++;
        if (due_v) begin
          if (cnt[due_a] == 0) m_err = 1'b1;
          else cnt[due_a]--;
        end
      end

      due_v = 1'b0;
      if (m_gi >= 0) begin
        m_ptr = m_gi;
        if (m_gi == LINK) begin
          exp_q.push_back({1'b0, 1'b1, 5'd31, src_data[m_gi]});
          due_v = 1'b1;
          due_a = 31;
        end else if (src_addr[m_gi] != 0) begin
          exp_q.push_back({1'b1, 1'b0, src_addr[m_gi], src_data[m_gi]});
          due_v = 1'b1;
          due_a = int'(src_addr[m_gi]);
        end
      end
    end
  end

  // Monitor: every visible write must match the oldest expected write.
  always @(negedge clk) begin
    logic [38:0] e;
    #1;
    if (wr_en || jump_and_link) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {25'd0, wr_en, jump_and_link, wr_addr, wr_data}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_port", {25'd0, wr_en, jump_and_link, wr_addr, wr_data}, {25'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [NS-1:0] g;
  int            a;

  initial begin
    rst = 1'b1; src_req = '0; src_addr = '0; src_data = '0;
    iss_valid = 1'b0; iss_addr = '0; qry_addr0 = 5'd31; qry_addr1 = 5'd7;
    step(); step();
    rst = 1'b0;
    at_neg();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_jal", 64'(jump_and_link), 64'd0);
    chk("rst_sb_err", 64'(sb_err), 64'd0);

    // Single write to r5
    step();
    src_req = 3'b001; src_addr[0] = 5'd5; src_data[0] = 32'hDEADBEEF;
    at_neg();
    chk("single_gnt", 64'(src_gnt), 64'b001);
    step();
    src_req = '0;
    at_neg();
    chk("single_wr_en", 64'(wr_en), 64'd1);
    chk("single_wr_addr", 64'(wr_addr), 64'd5);
    chk("single_wr_data", 64'(wr_data), 64'hDEADBEEF);

    // r0 write: granted, never written
    do_reset();
    src_req = 3'b010; src_addr[1] = 5'd0; src_data[1] = 32'h12345678;
    at_neg();
    chk("r0_gnt", 64'(src_gnt), 64'b010);
    step();
    src_req = '0;
    at_neg();
    chk("r0_wr_en", 64'(wr_en), 64'd0);

    // r7: two issues, two writes
    iss_valid = 1'b1; iss_addr = 5'd7; qry_addr0 = 5'd7;
    step(); step();
    iss_valid = 1'b0;
    src_req = 3'b001; src_addr[0] = 5'd7; src_data[0] = 32'hA5A5_0001;
    at_neg();
    chk("r7_busy", 64'(qry_busy0), 64'd1);
    step();
    src_data[0] = 32'hA5A5_0002;
    step();
    src_req = '0;
    step(); step();
    at_neg();
    chk("r7_idle", 64'(qry_busy0), 64'd0);
    chk("r7_no_err", 64'(sb_err), 64'd0);

    // Link write to r31 while r31 is pending
    iss_valid = 1'b1; iss_addr = 5'd31; qry_addr0 = 5'd31;
    step();
    iss_valid = 1'b0;
    src_req = 3'b100; src_data[2] = 32'h0040_0008;
    step();
    src_req = '0;
    at_neg();
    chk("link_jal", 64'(jump_and_link), 64'd1);
    chk("link_wr_en", 64'(wr_en), 64'd0);
    chk("link_wr_data", 64'(wr_data), 64'h0040_0008);
    step();
    at_neg();
    chk("link_busy_clr", 64'(qry_busy0), 64'd0);

    // Overflow on r3
    do_reset();
    iss_valid = 1'b1; iss_addr = 5'd3; qry_addr0 = 5'd3;
    for (int k = 1; k <= 4; k++) begin
      at_neg();
      chk("r3_iss_ready", 64'(iss_ready), 64'(k < 4));
      step();
    end
    iss_valid = 1'b0;
    at_neg();
    chk("r3_sb_err", 64'(sb_err), 64'd1);

    // Randomized traffic with occasional mid-burst resets
    for (int c = 0; c < 3000; c++) begin
      at_neg();
      g = src_gnt;
      step();
      rst = ($urandom_range(0, 99) < 2);
      for (int i = 0; i < NS; i++) begin
        if (!(src_req[i] && !g[i])) begin
          src_req[i]  = ($urandom_range(0, 99) < 50);
          src_addr[i] = 5'($urandom_range(0, 7));
          src_data[i] = $urandom;
        end
      end
      iss_valid = ($urandom_range(0, 99) < 45);
      a = $urandom_range(0, 8);
      iss_addr  = (a == 8) ? 5'd31 : 5'(a);
      a = $urandom_range(0, 8);
      qry_addr0 = (a == 8) ? 5'd31 : 5'(a);
      qry_addr1 = 5'($urandom_range(0, 31));
    end

    // Contention from reset
    step();
    rst = 1'b1; src_req = 3'b111; iss_valid = 1'b0;
    step();
    rst = 1'b0;
    at_neg();
    chk("cont_gnt0", 64'(src_gnt), 64'b001);
    step();
    at_neg();
    chk("cont_gnt1", 64'(src_gnt), 64'b010);
    step();
    src_req = 3'b110;
    at_neg();
    chk("cont_gnt2", 64'(src_gnt), 64'b100);
    step();
    src_req = '0;
    step(); step(); step();
    at_neg();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Shares the register file's single write port, plus its jump_and_link link-write path, among NUM_SRC write-back requesters (ALU, load unit, link) using round-robin arbitration.
- Keeps a per-register pending-write scoreboard, so the decode stage can stall reads of registers that have an outstanding producer.
- Sits between the execute/memory write-back sources and register_file; drives the register file's wr_en, wr_addr, wr_data and jump_and_link.

Parameters:
- NUM_SRC, 3, number of write-back requesters.
- LINK_SRC, 2, index of the requester whose writes go through jump_and_link to r31.
- PEND_W, 2, width of each per-register pending counter (max PEND_MAX = 2^PEND_W-1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- src_req  in  NUM_SRC  per-source write request.
- src_addr  in  NUM_SRC x 5  per-source destination register; ignored for LINK_SRC.
- src_data  in  NUM_SRC x 32  per-source write data.
- src_gnt  out  NUM_SRC  one-hot grant; combinational.
- iss_valid  in  1  producer issued: mark iss_addr pending.
- iss_addr  in  5  destination register of the issued producer.
- iss_ready  out  1  low when the iss_addr counter is at PEND_MAX; combinational.
- qry_addr0, qry_addr1  in  5 each  read-hazard query addresses.
- qry_busy0, qry_busy1  out  1 each  pending count nonzero; combinational.
- wr_en  out  1  to register_file; registered.
- wr_addr  out  5  to register_file; registered.
- wr_data  out  32  to register_file; registered.
- jump_and_link  out  1  to register_file; registered.
- sb_err  out  1  sticky scoreboard underflow or overflow flag.

Behaviour:
- Reset values (rst high at an edge): wr_en=0, wr_addr=0, wr_data=0, jump_and_link=0, sb_err=0. All counters are 0. The round-robin pointer is NUM_SRC-1, so src 0 has priority first. src_gnt is forced to 0 while rst is high. In-flight requests are dropped; no write is issued.
- Handshake is valid/ready. A requester holds src_req, src_addr and src_data stable until src_gnt is seen high. A transfer occurs in a cycle where src_req[i] & src_gnt[i].
- Arbitration:
  - At most one grant per cycle; a grant is issued whenever any request is asserted.
  - Search starts at pointer+1 with modulo-NUM_SRC wrap. The pointer updates to the granted index on a transfer.
  - A sole requester is granted every cycle.
- Latency: transfer in cycle t → outputs valid in cycle t+1 → register file written at the end of t+1. A query in t+2 shows not-busy; a register-file read issued in t+2 returns the new data in t+3.
- Output encoding, cycle t+1:
  - Normal source: wr_en = (src_addr != 0), wr_addr = src_addr, wr_data = src_data, jump_and_link = 0.
  - LINK_SRC: wr_en = 0, jump_and_link = 1, wr_addr = 31, wr_data = src_data.
  - No transfer: wr_en = 0 and jump_and_link = 0; wr_addr and wr_data hold their previous values.
- Scoreboard, per register r:
  - Set event: iss_valid & iss_ready & iss_addr == r & r != 0.
  - Clear event: wr_en or jump_and_link asserted in the current cycle with the target equal to r (r31 for link).
  - Set and clear in the same cycle leave the count unchanged.
  - Clear with count 0: count stays 0 and sb_err is set.
  - iss_valid while iss_ready is low: no change and sb_err is set.
  - r0 is never busy and is never counted; a grant to r0 causes no scoreboard change.
- sb_err clears only on rst.

Decomposition:
- Shared package mips_pkg holds:
  - word_t (logic [31:0]) and reg_addr_t (logic [4:0]).
  - NUM_REGS = 32, ZERO_REG = 0, RA_REG = 31.
- One sub-module: rr_arbiter (parameter N; inputs req and a pointer-update enable; outputs a one-hot gnt; contains the pointer register).
- Scoreboard counters and the output register stage stay in the top module.

Test Plan:
- Single write: src0 req, addr=5, data=0xDEADBEEF in cycle 1. src_gnt=001 in cycle 1; wr_en=1, wr_addr=5, wr_data=0xDEADBEEF in cycle 2; a register-file read of r5 issued in cycle 3 returns 0xDEADBEEF in cycle 4.
- Contention: all three sources request continuously from reset. Grant sequence is src0, src1, src2, src0, ...; with only src1 and src2 requesting after a src1 grant, the next grant is src2.
- r0 write: src1 addr=0, data=0x12345678. Grant is issued, wr_en stays 0 and the r0 count remains 0.
- Scoreboard: issue r7 twice, then two writes to r7. qry_busy0 (qry_addr0=7) is high until the cycle after the second wr_en. Issue and write of r7 in the same cycle leave the count unchanged.
- Link: src2 req, data=0x00400008 with r31 pending. jump_and_link=1 and wr_en=0 in the next cycle; r31 reads back 0x00400008; qry_busy on r31 clears.
- Error and reset: PEND_W=2, issue r3 four times → iss_ready low on the 4th and sb_err=1. Assert rst mid-burst → all outputs, counters and sb_err return to 0, and the next grant goes to src0.
